// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// Lane/word widths are fixed by the 32-bit instruction word.
package imem_loader_pkg;

  localparam int IMEM_DEPTH = 64;
  localparam int WORD_W     = 32;
  localparam int BYTE_W     = 8;
  localparam int LANES      = WORD_W / BYTE_W;
  localparam int LEN_W      = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a little-endian byte stream into a 32-bit word, lane 0 first.
// full flags the shift that fills the last lane, so the FSM can leave RECV on that edge.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              shift,
  input  logic              clear,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              full
);

  logic [1:0]        cnt_reg;
  logic [BYTE_W-1:0] lane_reg [LANES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= 2'd0;
    end else if (clear) begin
      cnt_reg <= 2'd0;
    end else if (shift) begin
      cnt_reg <= cnt_reg + 2'd1;
    end
  end

  // Each lane owns its own register so no two processes drive the same bits.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          lane_reg[gi] <= '0;
        end else if (shift && !clear && (cnt_reg == 2'(gi))) begin
          lane_reg[gi] <= byte_in;
        end
      end
      assign word[gi*BYTE_W +: BYTE_W] = lane_reg[gi];
    end
  endgenerate

  assign full = shift && !clear && (cnt_reg == 2'(LANES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot/on-demand loader: receives bytes, packs them into words and writes
// them to instruction memory from address 0 while holding the CPU.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [WORD_W-1:0] wa,
  output logic [WORD_W-1:0] wd,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  state_t            state_reg, state_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [LEN_W-1:0]  word_idx_reg, word_idx_next;
  logic              err_reg, err_next;
  logic              pack_shift, pack_clear, pack_full;
  logic [WORD_W-1:0] pack_word;

  imem_byte_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .shift   (pack_shift),
    .clear   (pack_clear),
    .byte_in (byte_data),
    .word    (pack_word),
    .full    (pack_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      len_reg      <= '0;
      word_idx_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      word_idx_reg <= word_idx_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    word_idx_next = word_idx_reg;
    err_next      = 1'b0;
    pack_shift    = 1'b0;
    pack_clear    = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (load_len == '0) begin
            state_next = ST_DONE;
          end else if (load_len > LEN_W'(DEPTH)) begin
            err_next = 1'b1;
          end else begin
            len_next      = load_len;
            word_idx_next = '0;
            pack_clear    = 1'b1;
            state_next    = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        pack_shift = byte_valid;
        if (pack_full) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (word_idx_reg == len_reg - LEN_W'(1)) begin
          state_next = ST_DONE;
        end else begin
          word_idx_next = word_idx_reg + LEN_W'(1);
          pack_clear    = 1'b1;
          state_next    = ST_RECV;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Every output is decoded from registered state only.
  assign byte_ready = (state_reg == ST_RECV);
  assign we         = (state_reg == ST_WRITE);
  assign cpu_hold   = (state_reg != ST_IDLE);
  assign done       = (state_reg == ST_DONE);
  assign err        = err_reg;
  assign wa         = {{(WORD_W - LEN_W - 2){1'b0}}, word_idx_reg, 2'b00};
  assign wd         = pack_word;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; a negedge monitor mirrors the memory write port.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  load_len = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, we, cpu_hold, done, err;
  logic [31:0] wa, wd;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic [31:0] last_wa = '0, last_wd = '0;
  logic [31:0] mem [64];

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we         (we),
    .wa         (wa),
    .wd         (wd),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we) begin
      we_cnt++;
      last_wa = wa;
      last_wd = wd;
      mem[wa[7:2]] = wd;
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-16s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("byte_timeout", 32'(byte_ready), 32'd1);
    step();
    byte_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], (k < 3) ? gap : 0);
  endtask

  task automatic start_load(input logic [6:0] len);
    start    = 1'b1;
    load_len = len;
    step();
    start    = 1'b0;
  endtask

  int wc, dc, ec;

  initial begin
    // Reset held with byte_valid asserted: everything idle.
    byte_valid = 1'b1;
    step();
    step();
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wa", wa, 32'h0);
    chk("rst_wd", wd, 32'h0);
    byte_valid = 1'b0;
    reset = 1'b0;
    step();

    // Single-word load.
    dc = done_cnt;
    start_load(7'd1);
    chk("l1_byte_ready", 32'(byte_ready), 32'd1);
    chk("l1_cpu_hold", 32'(cpu_hold), 32'd1);
    send_word(32'hE04F000F, 0);
    chk("l1_we", 32'(we), 32'd1);
    chk("l1_wa", wa, 32'h0);
    chk("l1_wd", wd, 32'hE04F000F);
    chk("l1_ready_in_wr", 32'(byte_ready), 32'd0);
    step();
    chk("l1_done", 32'(done), 32'd1);
    chk("l1_hold_done", 32'(cpu_hold), 32'd1);
    chk("l1_we_off", 32'(we), 32'd0);
    step();
    chk("l1_done_off", 32'(done), 32'd0);
    chk("l1_hold_off", 32'(cpu_hold), 32'd0);
    chk("l1_done_pulses", 32'(done_cnt - dc), 32'd1);

    // Two words with an idle cycle between bytes.
    wc = we_cnt;
    start_load(7'd2);
    send_word(32'h44332211, 1);
    chk("l2_w0_we", 32'(we), 32'd1);
    chk("l2_w0_wa", wa, 32'h0);
    chk("l2_w0_wd", wd, 32'h44332211);
    step();
    chk("l2_back_recv", 32'(byte_ready), 32'd1);
    send_word(32'hE2802005, 1);
    chk("l2_w1_we", 32'(we), 32'd1);
    chk("l2_w1_wa", wa, 32'h4);
    chk("l2_w1_wd", wd, 32'hE2802005);
    step();
    chk("l2_done", 32'(done), 32'd1);
    step();
    chk("l2_we_pulses", 32'(we_cnt - wc), 32'd2);

    // Zero-length load goes straight to DONE.
    wc = we_cnt;
    start_load(7'd0);
    chk("l0_done", 32'(done), 32'd1);
    chk("l0_hold", 32'(cpu_hold), 32'd1);
    chk("l0_we", 32'(we), 32'd0);
    step();
    chk("l0_idle", 32'(cpu_hold), 32'd0);
    chk("l0_no_write", 32'(we_cnt - wc), 32'd0);

    // Oversized request.
    ec = err_cnt;
    start_load(7'd65);
    chk("big_err", 32'(err), 32'd1);
    chk("big_hold", 32'(cpu_hold), 32'd0);
    chk("big_ready", 32'(byte_ready), 32'd0);
    chk("big_we", 32'(we), 32'd0);
    step();
    chk("big_err_off", 32'(err), 32'd0);
    chk("big_still_idle", 32'(byte_ready), 32'd0);
    chk("big_err_pulses", 32'(err_cnt - ec), 32'd1);

    // Reset mid-word, then a fresh load.
    wc = we_cnt;
    dc = done_cnt;
    start_load(7'd1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    reset = 1'b1;
    #1;
    chk("mr_ready", 32'(byte_ready), 32'd0);
    chk("mr_hold", 32'(cpu_hold), 32'd0);
    step();
    reset = 1'b0;
    repeat (3) step();
    chk("mr_no_we", 32'(we_cnt - wc), 32'd0);
    chk("mr_no_done", 32'(done_cnt - dc), 32'd0);
    start_load(7'd1);
    send_word(32'hDDCCBBAA, 0);
    chk("mr_wa", wa, 32'h0);
    chk("mr_wd", wd, 32'hDDCCBBAA);
    step();
    step();

    // Full-depth load with a stray start in the middle.
    wc = we_cnt;
    dc = done_cnt;
    start_load(7'd64);
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (i == 10 && k == 0) begin
          start = 1'b1;
          load_len = 7'd1;
        end
        send_byte(8'(i * 4 + k), 0);
        start = 1'b0;
      end
      step();
    end
    chk("full_done", 32'(done), 32'd1);
    step();
    chk("full_we_pulses", 32'(we_cnt - wc), 32'd64);
    chk("full_last_wa", last_wa, 32'hFC);
    chk("full_last_wd", last_wd, 32'hFFFEFDFC);
    chk("full_mem0", mem[0], 32'h03020100);
    chk("full_mem5", mem[5], 32'h17161514);
    chk("full_mem11", mem[11], 32'h2F2E2D2C);
    chk("full_done_cnt", 32'(done_cnt - dc), 32'd1);
    chk("full_idle", 32'(cpu_hold), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
